demux_1x2_buf: RTL

//  Buffered 1-to-2 demultiplexer: the splitting counterpart of the 2:1 select mux.

---
 rtl/demux_1x2_buf.sv | 101 ++++++++++
 1 files changed

// File: rtl/demux_1x2_buf.sv
//==============================================================================
// Module  : demux_1x2_buf
// Brief   : Buffered 1-to-2 demultiplexer with an independent FIFO per output,
//           so a stalled consumer only blocks traffic routed to it.
// Revision: 1.0
//==============================================================================
`default_nettype none

module demux_1x2_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         X,
    input  logic                     S,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         Y1,
    output logic                     Y1_valid,
    input  logic                     Y1_ready,
    output logic [$clog2(DEPTH):0]   Y1_count,
    output logic [WIDTH-1:0]         Y2,
    output logic                     Y2_valid,
    input  logic                     Y2_ready,
    output logic [$clog2(DEPTH):0]   Y2_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [1:0]       w_sel;
    logic [1:0]       w_ready;
    logic [1:0]       w_push;
    logic [1:0]       w_valid;
    logic [CW-1:0]    w_count [2];
    logic [WIDTH-1:0] w_head  [2];

    assign w_sel   = {S, ~S};
    assign w_ready = {Y2_ready, Y1_ready};

    // Acceptance looks only at registered occupancy, never at the consumer
    // ready lines, so a pop in the same cycle cannot free a slot early.
    assign in_ready = ((S ? w_count[1] : w_count[0]) != C_FULL);
    assign w_push   = {2{in_valid & in_ready}} & w_sel;

    generate
        for (genvar k = 0; k < 2; k++) begin : g_fifo
            logic [WIDTH-1:0] r_mem [DEPTH];
            logic [PW-1:0]    r_wr_ptr;
            logic [PW-1:0]    r_rd_ptr;
            logic [CW-1:0]    r_count;
            logic             w_not_empty;
            logic             w_pop;

            assign w_not_empty = (r_count != '0);
            assign w_pop       = w_not_empty & w_ready[k];

            always_ff @(posedge clk) begin
                if (w_push[k]) begin
                    r_mem[r_wr_ptr] <= X;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push[k]) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    case ({w_push[k], w_pop})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end

            assign w_valid[k] = w_not_empty;
            assign w_count[k] = r_count;
            assign w_head[k]  = w_not_empty ? r_mem[r_rd_ptr] : '0;
        end
    endgenerate

    assign Y1       = w_head[0];
    assign Y1_valid = w_valid[0];
    assign Y1_count = w_count[0];
    assign Y2       = w_head[1];
    assign Y2_valid = w_valid[1];
    assign Y2_count = w_count[1];

endmodule

`default_nettype wire
